// File: rtl/paddle_ctrl.sv
// rtl/paddle_ctrl.sv - keypad-driven Pong paddle, pause and recentre controller
module paddle_ctrl #(
  parameter int POS_W       = 10,
  parameter int POS_MIN     = 0,
  parameter int POS_MAX     = 400,
  parameter int POS_INIT    = 200,
  parameter int STEP        = 4,
  parameter int STEP_DIV    = 250000,
  parameter int HOLD_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       keycode,
  input  logic             key_pressed,
  output logic [POS_W-1:0] p1_y,
  output logic [POS_W-1:0] p2_y,
  output logic             paused,
  output logic             pause_pulse,
  output logic             recentre_pulse
);

  // Key slots: P1 up, P1 down, P2 up, P2 down, pause, recentre.
  localparam int NKEYS = 6;
  localparam int K_P1U = 0;
  localparam int K_P1D = 1;
  localparam int K_P2U = 2;
  localparam int K_P2D = 3;
  localparam int K_PAU = 4;
  localparam int K_REC = 5;

  localparam int TW = $clog2(HOLD_CYCLES + 1);
  localparam int CW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;

  // Position arithmetic one bit wider so up/down limits never wrap.
  localparam logic [POS_W:0] MIN_E    = (POS_W + 1)'(POS_MIN);
  localparam logic [POS_W:0] MAX_E    = (POS_W + 1)'(POS_MAX);
  localparam logic [POS_W:0] STEP_E   = (POS_W + 1)'(STEP);
  localparam logic [POS_W:0] LIM_UP   = (POS_W + 1)'(POS_MIN + STEP);
  localparam logic [POS_W:0] LIM_DN   = (POS_W + 1)'(POS_MAX - STEP);
  localparam logic [POS_W-1:0] INIT_Y = POS_W'(POS_INIT);

  function automatic logic [3:0] key_code(input int k);
    case (k)
      K_P1U:   key_code = 4'd1;
      K_P1D:   key_code = 4'd7;
      K_P2U:   key_code = 4'd10;
      K_P2D:   key_code = 4'd12;
      K_PAU:   key_code = 4'd14;
      default: key_code = 4'd15;
    endcase
  endfunction

  function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] y,
                                                input logic up, input logic dn);
    logic [POS_W:0] ye;
    logic [POS_W:0] r;
    ye = {1'b0, y};
    r  = ye;
    if (up && !dn) begin
      r = (ye < LIM_UP) ? MIN_E : ye - STEP_E;
    end else if (dn && !up) begin
      r = (ye > LIM_DN) ? MAX_E : ye + STEP_E;
    end
    step_pos = POS_W'(r);
  endfunction

  logic [TW-1:0]    timer_q [NKEYS];
  logic [TW-1:0]    timer_d [NKEYS];
  logic [NKEYS-1:0] held;
  logic [NKEYS-1:0] held_prev_q;
  logic [NKEYS-1:0] rise;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             tick;
  logic [POS_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic             paused_q, paused_d;
  logic             pause_pulse_q, pause_pulse_d;
  logic             recentre_pulse_q, recentre_pulse_d;

  // Hold timers bridge the scanner's gaps: reload on a matching sample, otherwise run down.
  always_comb begin
    for (int k = 0; k < NKEYS; k++) begin
      timer_d[k] = timer_q[k];
      if (key_pressed && (keycode == key_code(k))) begin
        timer_d[k] = TW'(HOLD_CYCLES);
      end else if (timer_q[k] != '0) begin
        timer_d[k] = timer_q[k] - 1'b1;
      end
      held[k] = (timer_q[k] != '0);
      rise[k] = held[k] & ~held_prev_q[k];
    end
  end

  // Step tick divider runs freely, independent of pause and recentre.
  always_comb begin
    tick  = (cnt_q == CW'(STEP_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Paddle motion, pause toggle and recentre; recentre overrides a coincident tick.
  always_comb begin
    p1_d             = p1_q;
    p2_d             = p2_q;
    paused_d         = paused_q ^ rise[K_PAU];
    pause_pulse_d    = rise[K_PAU];
    recentre_pulse_d = rise[K_REC];
    if (rise[K_REC]) begin
      p1_d = INIT_Y;
      p2_d = INIT_Y;
    end else if (tick && !paused_q) begin
      p1_d = step_pos(p1_q, held[K_P1U], held[K_P1D]);
      p2_d = step_pos(p2_q, held[K_P2U], held[K_P2D]);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NKEYS; k++) begin
        timer_q[k] <= '0;
      end
      held_prev_q      <= '0;
      cnt_q            <= '0;
      p1_q             <= INIT_Y;
      p2_q             <= INIT_Y;
      paused_q         <= 1'b0;
      pause_pulse_q    <= 1'b0;
      recentre_pulse_q <= 1'b0;
    end else begin
      for (int k = 0; k < NKEYS; k++) begin
        timer_q[k] <= timer_d[k];
      end
      held_prev_q      <= held;
      cnt_q            <= cnt_d;
      p1_q             <= p1_d;
      p2_q             <= p2_d;
      paused_q         <= paused_d;
      pause_pulse_q    <= pause_pulse_d;
      recentre_pulse_q <= recentre_pulse_d;
    end
  end

  assign p1_y           = p1_q;
  assign p2_y           = p2_q;
  assign paused         = paused_q;
  assign pause_pulse    = pause_pulse_q;
  assign recentre_pulse = recentre_pulse_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb/tb_paddle_ctrl.sv - self-checking bench for paddle_ctrl
`timescale 1ns/1ps
module tb_paddle_ctrl;
  localparam int POS_W    = 10;
  localparam int POS_MIN  = 0;
  localparam int POS_MAX  = 20;
  localparam int POS_INIT = 8;
  localparam int STEP     = 4;
  localparam int STEP_DIV = 4;
  localparam int HOLD     = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       keycode = 4'd0;
  logic             key_pressed = 1'b0;
  logic [POS_W-1:0] p1_y, p2_y;
  logic             paused, pause_pulse, recentre_pulse;

  paddle_ctrl #(
    .POS_W(POS_W), .POS_MIN(POS_MIN), .POS_MAX(POS_MAX), .POS_INIT(POS_INIT),
    .STEP(STEP), .STEP_DIV(STEP_DIV), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .keycode(keycode), .key_pressed(key_pressed),
    .p1_y(p1_y), .p2_y(p2_y), .paused(paused),
    .pause_pulse(pause_pulse), .recentre_pulse(recentre_pulse)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a key is held if it was sampled within the last HOLD cycles.
  int key_tab [6] = '{1, 7, 10, 12, 14, 15};
  int m_cyc;
  int m_last [6];
  bit m_hprev [6];
  bit m_paused, m_pp, m_rp;
  int m_y1, m_y2;

  typedef struct {
    int kc;
    int alt;
    bit kp;
    int n;
    int e1;
    int e2;
    bit ep;
  } vec_t;
  vec_t tab [6];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int move(input int y, input bit up, input bit dn);
    if (up && !dn) return (y - STEP < POS_MIN) ? POS_MIN : y - STEP;
    if (dn && !up) return (y + STEP > POS_MAX) ? POS_MAX : y + STEP;
    return y;
  endfunction

  function automatic void model_reset();
    m_cyc = 0;
    for (int k = 0; k < 6; k++) begin
      m_last[k]  = -1000;
      m_hprev[k] = 1'b0;
    end
    m_paused = 1'b0; m_pp = 1'b0; m_rp = 1'b0;
    m_y1 = POS_INIT; m_y2 = POS_INIT;
  endfunction

  function automatic void model_step(input int kc, input bit kp);
    bit held [6];
    bit rise [6];
    bit tick;
    for (int k = 0; k < 6; k++) begin
      held[k] = (m_cyc - m_last[k] >= 1) && (m_cyc - m_last[k] <= HOLD);
      rise[k] = held[k] && !m_hprev[k];
    end
    tick = (m_cyc % STEP_DIV) == STEP_DIV - 1;
    if (rise[5]) begin
      m_y1 = POS_INIT; m_y2 = POS_INIT;
    end else if (tick && !m_paused) begin
      m_y1 = move(m_y1, held[0], held[1]);
      m_y2 = move(m_y2, held[2], held[3]);
    end
    m_pp = rise[4];
    m_rp = rise[5];
    if (rise[4]) m_paused = !m_paused;
    for (int k = 0; k < 6; k++) begin
      m_hprev[k] = held[k];
      if (kp && kc == key_tab[k]) m_last[k] = m_cyc;
    end
    m_cyc++;
  endfunction

  task automatic check_model();
    check("p1_y", int'(p1_y), m_y1);
    check("p2_y", int'(p2_y), m_y2);
    check("paused", int'(paused), int'(m_paused));
    check("pause_pulse", int'(pause_pulse), int'(m_pp));
    check("recentre_pulse", int'(recentre_pulse), int'(m_rp));
  endtask

  task automatic run_cycle(input int kc, input bit kp);
    keycode = 4'(kc);
    key_pressed = kp;
    @(posedge clk);
    model_step(kc, kp);
    #1;
    check_model();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_p1"}, int'(p1_y), 8);
    check({tag, "_p2"}, int'(p2_y), 8);
    check({tag, "_paused"}, int'(paused), 0);
    check({tag, "_pp"}, int'(pause_pulse), 0);
    check({tag, "_rp"}, int'(recentre_pulse), 0);
  endtask

  // Async reset pulse placed between clock edges; outputs must react with no edge.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_vals(tag);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int np, nr, kc;
    bit kp;

    tab[0] = '{kc: 12, alt: 12, kp: 1, n: 4,  e1: 8, e2: 12, ep: 0};
    tab[1] = '{kc: 12, alt: 12, kp: 1, n: 4,  e1: 8, e2: 16, ep: 0};
    tab[2] = '{kc: 12, alt: 12, kp: 1, n: 4,  e1: 8, e2: 20, ep: 0};
    tab[3] = '{kc: 12, alt: 12, kp: 1, n: 4,  e1: 8, e2: 20, ep: 0};
    tab[4] = '{kc: 10, alt: 12, kp: 1, n: 16, e1: 8, e2: 20, ep: 0};
    tab[5] = '{kc: 10, alt: 10, kp: 1, n: 12, e1: 8, e2: 16, ep: 0};

    // Power-on reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("por");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Table: P2 down to the clamp, both P2 keys together, then release timing of key 12
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < tab[i].n; j++) begin
        run_cycle((j % 2 == 0) ? tab[i].kc : tab[i].alt, tab[i].kp);
      end
      check("tab_p1", int'(p1_y), tab[i].e1);
      check("tab_p2", int'(p2_y), tab[i].e2);
      check("tab_paused", int'(paused), int'(tab[i].ep));
    end

    // Intermittent key 1 samples every 4th cycle
    do_reset("rst2");
    for (int j = 0; j < 40; j++) run_cycle(1, (j % 4) == 0);
    check("s2_p1", int'(p1_y), 0);
    check("s2_p2", int'(p2_y), 8);
    for (int j = 0; j < 16; j++) run_cycle(0, 1'b0);
    check("s2_p1_stop", int'(p1_y), 0);
    do_reset("rst_async");

    // Pause, movement frozen, unpause resumes
    np = 0;
    for (int j = 0; j < 3; j++) begin run_cycle(14, 1'b1); np += int'(pause_pulse); end
    for (int j = 0; j < 12; j++) begin run_cycle(0, 1'b0); np += int'(pause_pulse); end
    check("s4_pulses1", np, 1);
    check("s4_paused1", int'(paused), 1);
    for (int j = 0; j < 12; j++) run_cycle(7, 1'b1);
    check("s4_frozen", int'(p1_y), 8);
    np = 0;
    for (int j = 0; j < 3; j++) begin run_cycle(14, 1'b1); np += int'(pause_pulse); end
    for (int j = 0; j < 12; j++) begin run_cycle(7, 1'b1); np += int'(pause_pulse); end
    check("s4_pulses2", np, 1);
    check("s4_paused2", int'(paused), 0);
    check("s4_resume", int'(p1_y > 8), 1);

    // Recentre rise coinciding with a tick while key 7 is still held
    do_reset("rst5");
    for (int j = 0; j < 8; j++) run_cycle(7, 1'b1);
    check("s5_p1_16", int'(p1_y), 16);
    run_cycle(7, 1'b1);
    run_cycle(7, 1'b1);
    run_cycle(15, 1'b1);
    nr = int'(recentre_pulse);
    run_cycle(0, 1'b0);
    nr += int'(recentre_pulse);
    check("s5_p1", int'(p1_y), 8);
    check("s5_p2", int'(p2_y), 8);
    check("s5_rp", int'(recentre_pulse), 1);
    for (int j = 0; j < 6; j++) begin run_cycle(0, 1'b0); nr += int'(recentre_pulse); end
    check("s5_rp_count", nr, 1);

    // Unmapped codes change nothing
    do_reset("rst6");
    np = 0;
    for (int j = 0; j < 50; j++) begin
      case ($urandom_range(0, 2))
        0: kc = 2;
        1: kc = 5;
        default: kc = 0;
      endcase
      run_cycle(kc, 1'b1);
      np += int'(pause_pulse) + int'(recentre_pulse);
    end
    check("s6_p1", int'(p1_y), 8);
    check("s6_p2", int'(p2_y), 8);
    check("s6_paused", int'(paused), 0);
    check("s6_pulses", np, 0);

    // Randomized traffic with occasional asynchronous resets
    for (int j = 0; j < 3000; j++) begin
      if ($urandom_range(0, 3) != 0) kc = key_tab[$urandom_range(0, 5)];
      else kc = $urandom_range(0, 15);
      kp = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) do_reset("rnd_rst");
      run_cycle(kc, kp);
      check("range", int'(p1_y >= POS_MIN && p1_y <= POS_MAX && p2_y >= POS_MIN && p2_y <= POS_MAX), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
